// File: rtl/sobel_pkg.sv
// Shared types for the sobel window producer: pixel, 3x3 neighbourhood, column taps, FSM states.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  typedef logic [7:0] pixel_t;

  // Neighbourhood around the centre pixel; nw lands in the MSB byte.
  typedef struct packed {
    pixel_t nw;
    pixel_t n;
    pixel_t ne;
    pixel_t w;
    pixel_t e;
    pixel_t sw;
    pixel_t s;
    pixel_t se;
  } window_t;

  // One vertical column of the 3x3 shift array: row-2, row-1, current row.
  typedef struct packed {
    pixel_t t;
    pixel_t m;
    pixel_t b;
  } column_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_FILL_NEXT,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// Circular one-line delay: o_dat is the word pushed DEPTH pushes ago, valid whenever i_push is sampled.
// Latency: 1-clk registered read, prefetched so back-to-back pushes see the right word.
// Backpressure: none; caller pushes at most one word per clock.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_dat;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_inc;
  logic [AW-1:0] w_rd_addr;

  assign w_ptr_inc = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  // On a push, fetch the slot the next push will overwrite so its old contents are ready in time.
  assign w_rd_addr = i_push ? w_ptr_inc : r_ptr;
  assign o_dat     = r_dat;

  // Write pointer advances once per push.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
    end
  end

  // Storage and registered read; contents are stale after reset and masked by the caller.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_dat;
    end
    r_dat <= r_mem[w_rd_addr];
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into one edge-masked 3x3 neighbourhood per pixel, in (row,col) order.
// Latency: window for centre k-(H+1) is registered when pixel k is pushed; start rises the next clk.
// Backpressure: pix_ready drops while a window waits for done; at most one window outstanding.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_pix_in,
  input  logic        i_pix_valid,
  input  logic        i_pix_sof,
  output logic        o_pix_ready,
  output logic [63:0] o_window,
  output logic [9:0]  o_row,
  output logic [9:0]  o_col,
  output logic        o_start,
  input  logic        i_done,
  output logic        o_frame_done,
  output logic        o_frame_err
);

  localparam logic [9:0] LP_LAST_COL = 10'(H_PIXELS - 1);
  localparam logic [9:0] LP_LAST_ROW = 10'(V_LINES - 1);
  localparam logic [9:0] LP_ROWS     = 10'(V_LINES);

  state_e     r_state;
  logic       r_pix_ready;
  logic       r_start;
  logic       r_frame_done;
  logic       r_frame_err;
  window_t    r_window;
  logic [9:0] r_row;
  logic [9:0] r_col;
  logic [9:0] r_out_row;
  logic [9:0] r_out_col;
  logic [9:0] r_in_row;
  logic [9:0] r_in_col;
  column_t    r_c1;
  column_t    r_c2;

  pixel_t     w_lb1;
  pixel_t     w_lb2;
  pixel_t     w_push_pix;
  logic       w_accept;
  logic       w_push;
  logic       w_form;
  logic       w_top;
  logic       w_bot;
  logic       w_left;
  logic       w_right;
  window_t    w_win;

  assign w_accept   = i_pix_valid & r_pix_ready;
  // In IDLE only the sof pixel enters the pipeline; FLUSH feeds zeros to drain the last H+1 centres.
  assign w_push     = (w_accept & ((r_state != S_IDLE) | i_pix_sof)) | (r_state == S_FLUSH);
  assign w_push_pix = (r_state == S_FLUSH) ? '0 : i_pix_in;
  // A window completes on every push from the SE pixel of centre (0,0) onward, except restart pixels.
  assign w_form = (w_accept & ~i_pix_sof &
                   ((r_state == S_FILL_NEXT) |
                    ((r_state == S_FILL) & (r_in_row == 10'd1) & (r_in_col == 10'd1)))) |
                  (r_state == S_FLUSH);

  line_buffer #(.DEPTH(H_PIXELS), .W(8)) u_lb1 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_dat   (w_push_pix),
    .o_dat   (w_lb1)
  );

  line_buffer #(.DEPTH(H_PIXELS), .W(8)) u_lb2 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_dat   (w_lb1),
    .o_dat   (w_lb2)
  );

  assign w_top   = (r_out_row == 10'd0);
  assign w_bot   = (r_out_row == LP_LAST_ROW);
  assign w_left  = (r_out_col == 10'd0);
  assign w_right = (r_out_col == LP_LAST_COL);

  // Assemble the neighbourhood of the next centre, zeroing taps that fall outside the frame.
  always_comb begin
    w_win    = '0;
    w_win.nw = (w_top | w_left)  ? '0 : r_c2.t;
    w_win.n  = w_top             ? '0 : r_c1.t;
    w_win.ne = (w_top | w_right) ? '0 : w_lb2;
    w_win.w  = w_left            ? '0 : r_c2.m;
    w_win.e  = w_right           ? '0 : w_lb1;
    w_win.sw = (w_bot | w_left)  ? '0 : r_c2.b;
    w_win.s  = w_bot             ? '0 : r_c1.b;
    w_win.se = (w_bot | w_right) ? '0 : w_push_pix;
  end

  // Shift the two most recent columns; their stale contents after reset are masked by the counters.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_c2 <= r_c1;
      r_c1 <= {w_lb2, w_lb1, w_push_pix};
    end
  end

  // Frame sequencing, input/centre counters and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pix_ready  <= 1'b0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_window     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_in_row     <= '0;
      r_in_col     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pix_ready <= 1'b1;
          if (w_accept && i_pix_sof) begin
            r_in_row  <= '0;
            r_in_col  <= 10'd1;
            r_out_row <= '0;
            r_out_col <= '0;
            r_state   <= S_FILL;
          end
        end
        S_FILL, S_FILL_NEXT: begin
          if (w_accept && i_pix_sof) begin
            // Unexpected sof: flag it and treat this pixel as (0,0) of a fresh frame.
            r_frame_err <= 1'b1;
            r_in_row    <= '0;
            r_in_col    <= 10'd1;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_state     <= S_FILL;
          end else if (w_accept) begin
            if (r_in_col == LP_LAST_COL) begin
              r_in_col <= '0;
              r_in_row <= r_in_row + 10'd1;
            end else begin
              r_in_col <= r_in_col + 10'd1;
            end
          end
        end
        S_ISSUE: begin
          if (i_done) begin
            r_start <= 1'b0;
            if ((r_row == LP_LAST_ROW) && (r_col == LP_LAST_COL)) begin
              r_frame_done <= 1'b1;
              r_pix_ready  <= 1'b1;
              r_state      <= S_IDLE;
            end else if (r_in_row == LP_ROWS) begin
              r_state <= S_FLUSH;
            end else begin
              r_pix_ready <= 1'b1;
              r_state     <= S_FILL_NEXT;
            end
          end
        end
        default: begin
        end
      endcase
      if (w_form) begin
        r_window    <= w_win;
        r_row       <= r_out_row;
        r_col       <= r_out_col;
        r_start     <= 1'b1;
        r_pix_ready <= 1'b0;
        r_state     <= S_ISSUE;
        if (r_out_col == LP_LAST_COL) begin
          r_out_col <= '0;
          r_out_row <= r_out_row + 10'd1;
        end else begin
          r_out_col <= r_out_col + 10'd1;
        end
      end
    end
  end

  assign o_pix_ready  = r_pix_ready;
  assign o_window     = r_window;
  assign o_row        = r_row;
  assign o_col        = r_col;
  assign o_start      = r_start;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x3 frame; pixel (r,c) = {r, c+1} as hex nibbles.
module tb_sobel_window_gen;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk;
  logic        rst;
  logic [7:0]  pix;
  logic        valid;
  logic        sof;
  logic        done;
  logic        pix_ready;
  logic [63:0] window;
  logic [9:0]  row;
  logic [9:0]  col;
  logic        start;
  logic        frame_done;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]  px_q[$];   // {sof, pixel}
  logic [83:0] cap_q[$];  // {row, col, window} of each issued window
  int hold_row = -1;
  int hold_col = -1;
  int hold_n   = 0;

  sobel_window_gen #(.H_PIXELS(H), .V_LINES(V)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pix_in     (pix),
    .i_pix_valid  (valid),
    .i_pix_sof    (sof),
    .o_pix_ready  (pix_ready),
    .o_window     (window),
    .o_row        (row),
    .o_col        (col),
    .o_start      (start),
    .i_done       (done),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] px(input int r, input int c);
    if (r < 0 || r >= V || c < 0 || c >= H) return 8'h00;
    return 8'(16 * r + c + 1);
  endfunction

  function automatic logic [63:0] exp_win(input int r, input int c);
    return {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1),
            px(r, c+1), px(r+1, c-1), px(r+1, c), px(r+1, c+1)};
  endfunction

  // Consumer: record each window once, answer done next edge unless told to hold this centre.
  initial begin
    int hold;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst && start) begin
        cap_q.push_back({row, col, window});
        hold = (int'(row) == hold_row && int'(col) == hold_col) ? hold_n : 0;
        while (hold > 0 && start && !rst) begin
          @(negedge clk);
          hold--;
        end
        if (start && !rst) done = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    sof = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cap_q.delete();
    px_q.delete();
  endtask

  task automatic push_frame();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        px_q.push_back({1'(r == 0 && c == 0), px(r, c)});
  endtask

  task automatic feed();
    int i;
    int b;
    i = 0;
    b = 0;
    while (i < px_q.size() && b < 2000) begin
      @(negedge clk);
      {sof, pix} = px_q[i];
      valid = 1'b1;
      if (pix_ready) i++;
      b++;
    end
    @(negedge clk);
    valid = 1'b0;
    sof = 1'b0;
    n_cmp++;
    if (i != px_q.size()) begin
      n_err++;
      $display("FAIL feed_timeout: accepted %0d pixels, required %0d", i, px_q.size());
    end
  endtask

  task automatic wait_caps(input int n);
    int b;
    b = 0;
    while (cap_q.size() < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1;
    sof = 1'b1;
    pix = 8'hAA;
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
    if (start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", start); end
    if (window !== 64'd0) begin n_err++; $display("FAIL rst_window: got %h want 0", window); end
    if (row !== 10'd0) begin n_err++; $display("FAIL rst_row: got %0d want 0", row); end
    if (col !== 10'd0) begin n_err++; $display("FAIL rst_col: got %0d want 0", col); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    valid = 1'b0;
    sof = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pix_ready !== 1'b1 || start !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready: got ready %b start %b, want ready 1 start 0", pix_ready, start);
    end
  endtask

  task automatic test_ramp();
    int b;
    do_reset();
    push_frame();
    feed();
    b = 0;
    while (!(start && row == 10'd2 && col == 10'd3) && b < 500) begin
      @(negedge clk);
      b++;
    end
    n_cmp++;
    if (b >= 500) begin
      n_err++;
      $display("FAIL ramp_last_timeout: window (2,3) never issued");
    end
    @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b1 || start !== 1'b0) begin
      n_err++;
      $display("FAIL ramp_frame_done: got frame_done %b start %b, want 1 0", frame_done, start);
    end
    @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL ramp_frame_done_pulse: got %b one clk later, want 0", frame_done);
    end
    wait_caps(12);
    n_cmp++;
    if (cap_q.size() != 12) begin
      n_err++;
      $display("FAIL ramp_count: got %0d windows, want 12", cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== {10'(i / H), 10'(i % H), exp_win(i / H, i % H)}) begin
        n_err++;
        $display("FAIL ramp_win[%0d]: got %h, want %h", i, cap_q[i],
                 {10'(i / H), 10'(i % H), exp_win(i / H, i % H)});
      end
    end
    if (cap_q.size() == 12) begin
      n_cmp += 3;
      if (cap_q[0][63:0] !== 64'h0000_0000_0200_1112) begin
        n_err++; $display("FAIL ramp_w00: got %h want 0000000002001112", cap_q[0][63:0]);
      end
      if (cap_q[5][63:0] !== 64'h0102_0311_1321_2223) begin
        n_err++; $display("FAIL ramp_w11: got %h want 0102031113212223", cap_q[5][63:0]);
      end
      if (cap_q[11][63:0] !== 64'h1314_0023_0000_0000) begin
        n_err++; $display("FAIL ramp_w23: got %h want 1314002300000000", cap_q[11][63:0]);
      end
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL ramp_err: got %b want 0", frame_err); end
  endtask

  task automatic test_stall();
    logic [63:0] w0;
    do_reset();
    hold_row = 0;
    hold_col = 2;
    hold_n   = 20;
    push_frame();
    fork
      feed();
      begin
        int b;
        b = 0;
        while (!(start && row == 10'd0 && col == 10'd2) && b < 500) begin
          @(negedge clk);
          b++;
        end
        w0 = window;
        n_cmp++;
        if (w0 !== 64'h0000_0002_0412_1314) begin
          n_err++;
          $display("FAIL stall_w02: got %h want 0000000204121314", w0);
        end
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          n_cmp++;
          if (start !== 1'b1 || window !== w0 || row !== 10'd0 || col !== 10'd2 || pix_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got start %b ready %b row %0d col %0d win %h, want 1 0 0 2 %h",
                     k, start, pix_ready, row, col, window, w0);
          end
        end
      end
    join
    wait_caps(12);
    hold_row = -1;
    n_cmp++;
    if (cap_q.size() != 12) begin
      n_err++;
      $display("FAIL stall_count: got %0d windows, want 12", cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== {10'(i / H), 10'(i % H), exp_win(i / H, i % H)}) begin
        n_err++;
        $display("FAIL stall_win[%0d]: got %h, want %h", i, cap_q[i],
                 {10'(i / H), 10'(i % H), exp_win(i / H, i % H)});
      end
    end
  endtask

  task automatic test_pre_sof();
    do_reset();
    px_q.push_back({1'b0, 8'hEE});
    px_q.push_back({1'b0, 8'h55});
    px_q.push_back({1'b0, 8'h77});
    push_frame();
    feed();
    wait_caps(12);
    n_cmp++;
    if (cap_q.size() != 12) begin
      n_err++;
      $display("FAIL presof_count: got %0d windows, want 12", cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== {10'(i / H), 10'(i % H), exp_win(i / H, i % H)}) begin
        n_err++;
        $display("FAIL presof_win[%0d]: got %h, want %h", i, cap_q[i],
                 {10'(i / H), 10'(i % H), exp_win(i / H, i % H)});
      end
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL presof_err: got %b want 0", frame_err); end
  endtask

  task automatic test_sof_restart();
    do_reset();
    for (int k = 0; k < 7; k++) px_q.push_back({1'(k == 0), px(k / H, k % H)});
    push_frame();
    feed();
    wait_caps(14);
    n_cmp++;
    if (cap_q.size() != 14) begin
      n_err++;
      $display("FAIL restart_count: got %0d windows, want 14", cap_q.size());
    end
    for (int i = 0; i < 14 && i < cap_q.size(); i++) begin
      int j;
      j = (i < 2) ? i : i - 2;
      n_cmp++;
      if (cap_q[i] !== {10'(j / H), 10'(j % H), exp_win(j / H, j % H)}) begin
        n_err++;
        $display("FAIL restart_win[%0d]: got %h, want %h", i, cap_q[i],
                 {10'(j / H), 10'(j % H), exp_win(j / H, j % H)});
      end
    end
    n_cmp++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL restart_err: got %b want 1", frame_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold_row = 1;
    hold_col = 2;
    hold_n   = 200;
    push_frame();
    fork
      feed();
      begin
        int b;
        b = 0;
        while (!(start && row == 10'd1 && col == 10'd2) && b < 500) begin
          @(negedge clk);
          b++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (start !== 1'b0 || pix_ready !== 1'b0 || row !== 10'd0 || col !== 10'd0 || frame_err !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_outputs: got start %b ready %b row %0d col %0d err %b, want 0 0 0 0 0",
                   start, pix_ready, row, col, frame_err);
        end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    hold_row = -1;
    repeat (2) @(negedge clk);
    cap_q.delete();
    px_q.delete();
    push_frame();
    feed();
    wait_caps(12);
    n_cmp++;
    if (cap_q.size() != 12) begin
      n_err++;
      $display("FAIL midrst_count: got %0d windows, want 12", cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== {10'(i / H), 10'(i % H), exp_win(i / H, i % H)}) begin
        n_err++;
        $display("FAIL midrst_win[%0d]: got %h, want %h", i, cap_q[i],
                 {10'(i / H), 10'(i % H), exp_win(i / H, i % H)});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    sof = 1'b0;
    pix = 8'h00;
    test_reset();
    test_ramp();
    test_stall();
    test_pre_sof();
    test_sof_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
